// File: rtl/fp_add_sched_pkg.sv
// Shared types and constants for the FP32 adder scheduler.
package fp_add_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESP    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam int          FP32_W    = 32;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_add_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int          t;
    logic [IW-1:0] p;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        t   = 0;
        p   = '0;
        for (int k = 1; k <= N; k++) begin
            t = int'(last) + k;
            if (t >= N) t = t - N;
            p = IW'(t);
            if (!any && req[p]) begin
                any    = 1'b1;
                gnt[p] = 1'b1;
                idx    = p;
            end
        end
    end

endmodule

// File: rtl/fp_add_sched.sv
// Shares one FP32 adder core (enable/done) among N_REQ requesters, one op at a time,
// with a timeout guarding both the wait for done and the wait for done to clear.
module fp_add_sched
    import fp_add_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW = $clog2(TIMEOUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [FP32_W*N_REQ-1:0]  req_dataa,
    input  logic [FP32_W*N_REQ-1:0]  req_datab,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         resp_valid,
    output logic [FP32_W-1:0]        resp_result,
    output logic                     resp_err,
    output logic [FP32_W-1:0]        core_dataa,
    output logic [FP32_W-1:0]        core_datab,
    output logic                     core_enable,
    input  logic                     core_done,
    input  logic [FP32_W-1:0]        core_result
);

    state_t            state, state_nx;
    logic [IW-1:0]     last, gidx, arb_idx;
    logic [N_REQ-1:0]  arb_gnt;
    logic              arb_any;
    logic [CW-1:0]     cnt;
    logic              timeout_hit;
    logic [FP32_W-1:0] a_vec [N_REQ];
    logic [FP32_W-1:0] b_vec [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_vec[i] = req_dataa[FP32_W*i +: FP32_W];
        assign b_vec[i] = req_datab[FP32_W*i +: FP32_W];
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req  (req_valid),
        .last (last),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // In RELEASE a stuck-high done is abandoned after the timeout; no second response.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (arb_any)                  state_nx = S_WAIT;
            S_WAIT:    if (core_done || timeout_hit) state_nx = S_RESP;
            S_RESP:                                  state_nx = S_RELEASE;
            S_RELEASE: if (!core_done || timeout_hit) state_nx = S_IDLE;
            default:                                 state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered off the transition so each pulse lines up with the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last        <= IW'(N_REQ - 1);
            gidx        <= '0;
            cnt         <= '0;
            req_ready   <= '0;
            resp_valid  <= '0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            core_dataa  <= '0;
            core_datab  <= '0;
            core_enable <= 1'b0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            if (state_nx != state) cnt <= '0;
            else if (cnt != '1)    cnt <= cnt + CW'(1);
            unique case (state)
                S_IDLE: if (arb_any) begin
                    req_ready   <= arb_gnt;
                    gidx        <= arb_idx;
                    core_dataa  <= a_vec[arb_idx];
                    core_datab  <= b_vec[arb_idx];
                    core_enable <= 1'b1;
                end
                S_WAIT: if (core_done) begin
                    resp_result <= core_result;
                    resp_valid  <= N_REQ'(1) << gidx;
                    core_enable <= 1'b0;
                end else if (timeout_hit) begin
                    resp_result <= FP32_QNAN;
                    resp_err    <= 1'b1;
                    resp_valid  <= N_REQ'(1) << gidx;
                    core_enable <= 1'b0;
                end
                S_RESP:  last <= gidx;
                default: ;
            endcase
        end
    end

endmodule
